// File: rtl/asteroid_spawn_scheduler.sv
// ============================================================================
// Module   : asteroid_spawn_scheduler
// Brief    : Game progression: BCD survival score, level ramp and spawn pulses
//            with LFSR lanes. Optional macro DOUBLE_SPAWN_EN adds a second
//            spawn 2 clocks after each spawn issued at level >= 8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module asteroid_spawn_scheduler #(
   parameter int unsigned START_INTERVAL = 4,
   parameter int unsigned MIN_INTERVAL   = 1,
   parameter int unsigned LEVEL_UP_SECS  = 10,
   parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        secPulse,
   input  logic        start,
   input  logic        collision,
   output logic        timerEnable,
   output logic        spawnPulse,
   output logic [2:0]  spawnLane,
   output logic [3:0]  level,
   output logic [11:0] score,
   output logic        gameOver
);

   localparam logic [3:0] START_C = 4'(START_INTERVAL);
   localparam logic [3:0] MIN_C   = 4'(MIN_INTERVAL);
   localparam logic [3:0] LVLUP_C = 4'(LEVEL_UP_SECS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t      state_q;
   logic        timer_en_q, spawn_q, game_over_q;
   logic [2:0]  lane_q;
   logic [3:0]  level_q, lvl_sec_q, int_cnt_q;
   logic [11:0] score_q, score_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [3:0]  interval_d, int_diff, lvl_sec_inc, int_cnt_inc;
   logic        spawn_now;
`ifdef DOUBLE_SPAWN_EN
   logic [1:0]  pend_q;
`endif

   // Fibonacci LFSR, taps 8,6,5,4
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Guarded subtraction: level >= START falls straight to the floor
   always_comb begin
      interval_d = MIN_C;
      int_diff   = 4'd0;
      if (level_q < START_C) begin
         int_diff = START_C - level_q;
         if (int_diff > MIN_C) interval_d = int_diff;
      end
   end

   always_comb begin
      score_d = score_q;
      if (score_q != 12'h999) begin
         if (score_q[3:0] != 4'd9) begin
            score_d[3:0] = score_q[3:0] + 4'd1;
         end else begin
            score_d[3:0] = 4'd0;
            if (score_q[7:4] != 4'd9) begin
               score_d[7:4] = score_q[7:4] + 4'd1;
            end else begin
               score_d[7:4]  = 4'd0;
               score_d[11:8] = score_q[11:8] + 4'd1;
            end
         end
      end
   end

   assign lvl_sec_inc = lvl_sec_q + 4'd1;
   assign int_cnt_inc = int_cnt_q + 4'd1;
   assign spawn_now   = (int_cnt_inc >= interval_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_en_q  <= 1'b0;
         spawn_q     <= 1'b0;
         lane_q      <= 3'd0;
         level_q     <= 4'd0;
         score_q     <= 12'h000;
         game_over_q <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         lvl_sec_q   <= 4'd0;
         int_cnt_q   <= 4'd0;
`ifdef DOUBLE_SPAWN_EN
         pend_q      <= 2'd0;
`endif
      end else begin
         lfsr_q  <= lfsr_d;
         spawn_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_RUN;
                  timer_en_q <= 1'b1;
                  score_q    <= 12'h000;
                  level_q    <= 4'd0;
                  lvl_sec_q  <= 4'd0;
                  int_cnt_q  <= 4'd0;
               end
            end
            S_RUN: begin
               if (collision) begin
                  state_q     <= S_OVER;
                  timer_en_q  <= 1'b0;
                  game_over_q <= 1'b1;
`ifdef DOUBLE_SPAWN_EN
                  pend_q      <= 2'd0;
`endif
               end else begin
`ifdef DOUBLE_SPAWN_EN
                  // A fresh spawn on the same edge takes precedence over the pending one
                  if (pend_q != 2'd0) pend_q <= pend_q - 2'd1;
                  if (pend_q == 2'd1 && !(secPulse && spawn_now)) begin
                     spawn_q <= 1'b1;
                     lane_q  <= (lfsr_q[2:0] == lane_q) ? (lfsr_q[2:0] ^ 3'b001) : lfsr_q[2:0];
                  end
`endif
                  if (secPulse) begin
                     score_q <= score_d;
                     if (lvl_sec_inc == LVLUP_C) begin
                        lvl_sec_q <= 4'd0;
                        if (level_q != 4'd15) level_q <= level_q + 4'd1;
                     end else begin
                        lvl_sec_q <= lvl_sec_inc;
                     end
                     if (spawn_now) begin
                        int_cnt_q <= 4'd0;
                        spawn_q   <= 1'b1;
                        lane_q    <= lfsr_q[2:0];
`ifdef DOUBLE_SPAWN_EN
                        if (level_q >= 4'd8) pend_q <= 2'd2;
`endif
                     end else begin
                        int_cnt_q <= int_cnt_inc;
                     end
                  end
               end
            end
            S_OVER: begin
               if (!start) begin
                  state_q     <= S_IDLE;
                  game_over_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               timer_en_q  <= 1'b0;
               game_over_q <= 1'b0;
            end
         endcase
      end
   end

   assign timerEnable = timer_en_q;
   assign spawnPulse  = spawn_q;
   assign spawnLane   = lane_q;
   assign level       = level_q;
   assign score       = score_q;
   assign gameOver    = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_asteroid_spawn_scheduler.sv
// ============================================================================
// Module   : tb_asteroid_spawn_scheduler
// Brief    : Directed + randomized bench against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_asteroid_spawn_scheduler;

   localparam int         START = 4;
   localparam int         MINI  = 1;
   localparam int         LU    = 10;
   localparam logic [7:0] SEED  = 8'hA5;
`ifdef DOUBLE_SPAWN_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, secPulse, start, collision;
   logic        timerEnable, spawnPulse, gameOver;
   logic [2:0]  spawnLane;
   logic [3:0]  level;
   logic [11:0] score;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: state 0=IDLE 1=RUN 2=OVER, score/level as plain integers
   int         m_state, m_score, m_level, m_lsec, m_since, m_pend;
   logic [7:0] m_lfsr;
   logic       m_spawn;
   logic [2:0] m_lane;

   asteroid_spawn_scheduler #(
      .START_INTERVAL(START), .MIN_INTERVAL(MINI), .LEVEL_UP_SECS(LU), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .secPulse(secPulse), .start(start), .collision(collision),
      .timerEnable(timerEnable), .spawnPulse(spawnPulse), .spawnLane(spawnLane),
      .level(level), .score(score), .gameOver(gameOver)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_level = 0; m_lsec = 0; m_since = 0; m_pend = 0;
      m_lfsr = SEED; m_spawn = 1'b0; m_lane = 3'd0;
   endtask

   task automatic apply_reset();
      rst = 1'b1; secPulse = 1'b0; start = 1'b0; collision = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // Drive one clock of inputs, advance the model across the edge, settle 1ns after it
   task automatic cycle(input bit sp, input bit st, input bit col);
      logic [2:0] cur;
      bit fire, spawn_now;
      int lvl_old, iv;
      secPulse = sp; start = st; collision = col;
      @(posedge clk);
      cur = m_lfsr[2:0]; fire = 1'b0; spawn_now = 1'b0; lvl_old = m_level;
      m_spawn = 1'b0;
      case (m_state)
         0: if (st) begin
               m_state = 1; m_score = 0; m_level = 0; m_lsec = 0; m_since = 0;
            end
         1: if (col) begin
               m_state = 2; m_pend = 0;
            end else begin
               fire = (m_pend == 1);
               if (m_pend > 0) m_pend--;
               if (sp) begin
                  iv = START - m_level;
                  if (iv < MINI) iv = MINI;
                  if (m_score < 999) m_score++;
                  m_since++;
                  if (m_since >= iv) begin spawn_now = 1'b1; m_since = 0; end
                  m_lsec++;
                  if (m_lsec == LU) begin
                     m_lsec = 0;
                     if (m_level < 15) m_level++;
                  end
                  if (spawn_now) begin
                     m_spawn = 1'b1; m_lane = cur;
                     if (DBL && lvl_old >= 8) m_pend = 2;
                  end
               end
               if (fire && !spawn_now) begin
                  m_spawn = 1'b1;
                  m_lane  = (cur == m_lane) ? (cur ^ 3'b001) : cur;
               end
            end
         default: if (!st) m_state = 0;
      endcase
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if ({timerEnable, gameOver, spawnPulse} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: {te,go,sp}=%b expected 000", {timerEnable, gameOver, spawnPulse});
      end
      n_tests++;
      if (score !== 12'h000 || level !== 4'd0 || spawnLane !== 3'd0) begin
         n_fail++; $display("FAIL reset_values: score=%h level=%0d lane=%0d expected 000/0/0", score, level, spawnLane);
      end
   endtask

   task automatic test_first_spawn();
      cycle(0, 1, 0);
      n_tests++;
      if (timerEnable !== 1'b1 || gameOver !== 1'b0) begin
         n_fail++; $display("FAIL start_run: te=%b go=%b expected 1/0", timerEnable, gameOver);
      end
      for (int s = 1; s <= 4; s++) begin
         cycle(1, 1, 0);
         n_tests++;
         if (spawnPulse !== (s == 4) || (s == 4 && spawnLane !== m_lane)) begin
            n_fail++; $display("FAIL first_spawn sec%0d: sp=%b lane=%0d expected %b lane %0d", s, spawnPulse, spawnLane, s == 4, m_lane);
         end
         if (s == 4) begin
            n_tests++;
            if (score !== 12'h004 || level !== 4'd0 || timerEnable !== 1'b1) begin
               n_fail++; $display("FAIL first_spawn_state: score=%h level=%0d te=%b expected 004/0/1", score, level, timerEnable);
            end
         end
         cycle(0, 1, 0);
         n_tests++;
         if (spawnPulse !== 1'b0) begin
            n_fail++; $display("FAIL spawn_width sec%0d: sp=%b expected 0", s, spawnPulse);
         end
      end
   endtask

   task automatic test_level_up();
      for (int s = 5; s <= 11; s++) begin
         cycle(1, 1, 0);
         n_tests++;
         if (spawnPulse !== (s == 8 || s == 11) || level !== 4'(s >= 10) || score !== to_bcd(s)) begin
            n_fail++; $display("FAIL level_up sec%0d: sp=%b level=%0d score=%h expected sp=%b level=%0d", s, spawnPulse, level, score, (s == 8 || s == 11), s >= 10);
         end
         cycle(0, 1, 0);
      end
   endtask

   task automatic test_saturation();
      for (int s = 12; s <= 1001; s++) begin
         cycle(1, 1, 0);
         n_tests++;
         if ({spawnPulse, spawnLane, level, score} !== {m_spawn, m_lane, 4'(m_level), to_bcd(m_score)}) begin
            n_fail++; $display("FAIL saturation sec%0d: sp=%b lane=%0d lvl=%0d score=%h expected %b/%0d/%0d/%h",
                               s, spawnPulse, spawnLane, level, score, m_spawn, m_lane, m_level, to_bcd(m_score));
         end
         cycle(0, 1, 0);
      end
      cycle(1, 1, 0);
      n_tests++;
      if (score !== 12'h999 || level !== 4'd15 || spawnPulse !== 1'b1) begin
         n_fail++; $display("FAIL saturation_hold: score=%h level=%0d sp=%b expected 999/15/1", score, level, spawnPulse);
      end
   endtask

   task automatic test_collision();
      apply_reset();
      cycle(0, 1, 0);
      for (int s = 1; s <= 7; s++) begin cycle(1, 1, 0); cycle(0, 1, 0); end
      cycle(1, 1, 1);
      n_tests++;
      if (score !== 12'h007 || spawnPulse !== 1'b0 || gameOver !== 1'b1 || timerEnable !== 1'b0) begin
         n_fail++; $display("FAIL collision_wins: score=%h sp=%b go=%b te=%b expected 007/0/1/0", score, spawnPulse, gameOver, timerEnable);
      end
      repeat (3) cycle(1, 1, 0);
      n_tests++;
      if (gameOver !== 1'b1 || score !== 12'h007) begin
         n_fail++; $display("FAIL over_hold: go=%b score=%h expected 1/007", gameOver, score);
      end
      cycle(0, 0, 0);
      n_tests++;
      if (gameOver !== 1'b0 || timerEnable !== 1'b0) begin
         n_fail++; $display("FAIL over_to_idle: go=%b te=%b expected 0/0", gameOver, timerEnable);
      end
      cycle(0, 1, 0);
      n_tests++;
      if (timerEnable !== 1'b1 || score !== 12'h000) begin
         n_fail++; $display("FAIL restart: te=%b score=%h expected 1/000", timerEnable, score);
      end
   endtask

   task automatic test_async_reset();
      for (int s = 1; s <= 5; s++) begin cycle(1, 1, 0); cycle(0, 1, 0); end
      #3 rst = 1'b1;
      #1;
      n_tests++;
      if ({timerEnable, gameOver, spawnPulse, spawnLane, level, score} !== 22'd0) begin
         n_fail++; $display("FAIL async_reset: te=%b go=%b sp=%b lane=%0d lvl=%0d score=%h expected all 0",
                            timerEnable, gameOver, spawnPulse, spawnLane, level, score);
      end
      model_reset();
      secPulse = 1'b0; start = 1'b0; collision = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_random();
      bit sp, st, col;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         sp  = ($urandom % 3 == 0);
         st  = ($urandom % 8 != 0);
         col = ($urandom % 97 == 0);
         cycle(sp, st, col);
         n_tests++;
         if ({timerEnable, gameOver, spawnPulse, spawnLane, level, score} !==
             {m_state == 1, m_state == 2, m_spawn, m_lane, 4'(m_level), to_bcd(m_score)}) begin
            n_fail++; $display("FAIL random cyc%0d: te=%b go=%b sp=%b lane=%0d lvl=%0d score=%h expected %b/%b/%b/%0d/%0d/%h",
                               i, timerEnable, gameOver, spawnPulse, spawnLane, level, score,
                               m_state == 1, m_state == 2, m_spawn, m_lane, m_level, to_bcd(m_score));
         end
      end
   endtask

`ifdef DOUBLE_SPAWN_EN
   task automatic test_double_spawn();
      logic [2:0] lane1;
      apply_reset();
      cycle(0, 1, 0);
      for (int s = 1; s <= 80; s++) begin cycle(1, 1, 0); cycle(0, 1, 0); end
      n_tests++;
      if (level !== 4'd8) begin
         n_fail++; $display("FAIL double_level: level=%0d expected 8", level);
      end
      cycle(1, 1, 0);
      lane1 = spawnLane;
      cycle(0, 1, 0);
      n_tests++;
      if (spawnPulse !== 1'b0) begin
         n_fail++; $display("FAIL double_gap: sp=%b expected 0", spawnPulse);
      end
      cycle(0, 1, 0);
      n_tests++;
      if (spawnPulse !== 1'b1 || spawnLane === lane1 || spawnLane !== m_lane) begin
         n_fail++; $display("FAIL double_second: sp=%b lane=%0d first=%0d expected 1 lane %0d", spawnPulse, spawnLane, lane1, m_lane);
      end
      cycle(0, 1, 0);
      cycle(1, 1, 0);
      cycle(0, 1, 1);
      cycle(0, 1, 0);
      n_tests++;
      if (spawnPulse !== 1'b0 || gameOver !== 1'b1) begin
         n_fail++; $display("FAIL double_cancel: sp=%b go=%b expected 0/1", spawnPulse, gameOver);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_spawn();
      test_level_up();
      test_saturation();
      test_collision();
      test_async_reset();
      test_random();
`ifdef DOUBLE_SPAWN_EN
      test_double_spawn();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
